twiddle_addr_seq: RTL and testbench



---
 rtl/twiddle_addr_seq.sv | 137 +++++++++++++
 tb/tb_twiddle_addr_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_addr_seq.sv
// twiddle_addr_seq
//   Address sequencer for the 128-entry twiddle ROM of one radix-2^2 SDF stage.
//   It counts the stage input samples and maps each sample index to a twiddle
//   number in the 128-point numbering. It also produces enable, bypass and last
//   flags, which are delayed so that they line up with the ROM output.
//
// Parameters
//   LOG_N  log2 of the stage size (3, 5 or 7)
//   TW_FF  ROM output register count (1 = registered ROM, 0 = combinational ROM)
//
// Ports
//   clock      master clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_en      stage input sample present this cycle
//   in_sync    frame start; the sample on this cycle is index 0
//   tw_addr    twiddle number driven to the ROM address port
//   tw_en      twiddle data valid at the ROM output this cycle
//   tw_bypass  aligned twiddle number is 0 (multiplier passes data through)
//   tw_last    aligned twiddle belongs to sample index N-1
//   busy       a frame is partly received (index counter != 0)
module twiddle_addr_seq #(
  parameter int unsigned LOG_N = 7,
  parameter int unsigned TW_FF = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_en,
  input  logic       in_sync,
  output logic [6:0] tw_addr,
  output logic       tw_en,
  output logic       tw_bypass,
  output logic       tw_last,
  output logic       busy
);

  localparam int unsigned Shift = 7 - LOG_N;

  if (!(LOG_N == 3 || LOG_N == 5 || LOG_N == 7)) begin : g_bad_log_n
    $error("twiddle_addr_seq: LOG_N must be 3, 5 or 7");
  end
  if (TW_FF > 1) begin : g_bad_tw_ff
    $error("twiddle_addr_seq: TW_FF must be 0 or 1");
  end

  // Index counter
  logic [LOG_N-1:0] cnt_q, cnt_d;
  logic [LOG_N-1:0] idx;

  always_comb begin
    // A sync sample is index 0 regardless of the running count.
    idx = in_sync ? '0 : cnt_q;
    cnt_d = cnt_q;
    if (in_en && in_sync) begin
      cnt_d = LOG_N'(1);
    end else if (in_sync) begin
      cnt_d = '0;
    end else if (in_en) begin
      cnt_d = cnt_q + LOG_N'(1);  // natural wrap from N-1 to 0
    end
  end

  // Twiddle number: (k * m) scaled into the 128-point numbering
  logic [1:0]       quarter;
  logic [LOG_N-3:0] k;
  logic [1:0]       m;
  logic [6:0]       prod;
  logic [6:0]       num;
  logic             byp_hit;
  logic             last_hit;

  always_comb begin
    quarter = idx[LOG_N-1 -: 2];
    k       = idx[LOG_N-3:0];
    // Quarters 01 and 10 swap multipliers (bit-reversed quarter order).
    unique case (quarter)
      2'b00:   m = 2'd0;
      2'b01:   m = 2'd2;
      2'b10:   m = 2'd1;
      default: m = 2'd3;
    endcase
    prod     = 7'(k) * 7'(m);  // max 31*3 = 93, fits in 7 bits
    num      = prod << Shift;
    byp_hit  = in_en && (num == 7'd0);
    last_hit = in_en && (&idx);
  end

  // Stage A: address plus flags, one cycle after the sample
  logic [6:0] addr_q;
  logic       en_a_q, byp_a_q, last_a_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      en_a_q   <= 1'b0;
      byp_a_q  <= 1'b0;
      last_a_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      if (in_en) begin
        addr_q <= num;  // address holds across bubbles
      end
      en_a_q   <= in_en;
      byp_a_q  <= byp_hit;
      last_a_q <= last_hit;
    end
  end

  assign tw_addr = addr_q;
  assign busy    = (cnt_q != '0);

  // Flag delay matching the ROM output register
  if (TW_FF == 1) begin : g_flag_ff
    logic en_b_q, byp_b_q, last_b_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        en_b_q   <= 1'b0;
        byp_b_q  <= 1'b0;
        last_b_q <= 1'b0;
      end else begin
        en_b_q   <= en_a_q;
        byp_b_q  <= byp_a_q;
        last_b_q <= last_a_q;
      end
    end

    assign tw_en     = en_b_q;
    assign tw_bypass = byp_b_q;
    assign tw_last   = last_b_q;
  end else begin : g_flag_comb
    assign tw_en     = en_a_q;
    assign tw_bypass = byp_a_q;
    assign tw_last   = last_a_q;
  end

endmodule

// File: tb/tb_twiddle_addr_seq.sv
module tb_twiddle_addr_seq;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_en = 1'b0;
  logic in_sync = 1'b0;

  int total = 0;
  int bad = 0;

  // LOG_N=7, TW_FF=1
  logic [6:0] a7;
  logic e7, b7, l7, y7;
  // LOG_N=5, TW_FF=1
  logic [6:0] a5;
  logic e5, b5, l5, y5;
  // LOG_N=3, TW_FF=1
  logic [6:0] a3;
  logic e3, b3, l3, y3;
  // LOG_N=7, TW_FF=0
  logic [6:0] af;
  logic ef, bf, lf, yf;

  always #5 clock = ~clock;

  twiddle_addr_seq #(.LOG_N(7), .TW_FF(1)) dut7 (
    .clock(clock), .reset_n(reset_n), .in_en(in_en), .in_sync(in_sync),
    .tw_addr(a7), .tw_en(e7), .tw_bypass(b7), .tw_last(l7), .busy(y7)
  );
  twiddle_addr_seq #(.LOG_N(5), .TW_FF(1)) dut5 (
    .clock(clock), .reset_n(reset_n), .in_en(in_en), .in_sync(in_sync),
    .tw_addr(a5), .tw_en(e5), .tw_bypass(b5), .tw_last(l5), .busy(y5)
  );
  twiddle_addr_seq #(.LOG_N(3), .TW_FF(1)) dut3 (
    .clock(clock), .reset_n(reset_n), .in_en(in_en), .in_sync(in_sync),
    .tw_addr(a3), .tw_en(e3), .tw_bypass(b3), .tw_last(l3), .busy(y3)
  );
  twiddle_addr_seq #(.LOG_N(7), .TW_FF(0)) dut7f0 (
    .clock(clock), .reset_n(reset_n), .in_en(in_en), .in_sync(in_sync),
    .tw_addr(af), .tw_en(ef), .tw_bypass(bf), .tw_last(lf), .busy(yf)
  );

  // Active edge then 1 time unit: outputs settled, inputs may change.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_en = 1'b0;
    in_sync = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    total++; if ({a7, e7, b7, l7, y7} !== 11'd0) begin bad++;
      $display("FAIL reset_dut7 got=%b want=0", {a7, e7, b7, l7, y7}); end
    total++; if ({a5, e5, b5, l5, y5} !== 11'd0) begin bad++;
      $display("FAIL reset_dut5 got=%b want=0", {a5, e5, b5, l5, y5}); end
    total++; if ({a3, e3, b3, l3, y3} !== 11'd0) begin bad++;
      $display("FAIL reset_dut3 got=%b want=0", {a3, e3, b3, l3, y3}); end
    total++; if ({af, ef, bf, lf, yf} !== 11'd0) begin bad++;
      $display("FAIL reset_dut7f0 got=%b want=0", {af, ef, bf, lf, yf}); end
    reset_n = 1'b1;
  endtask

  // Continuous frame of 128 samples with sync at sample 0. dut5 and dut3 see
  // back-to-back frames on the same stream.
  task automatic test_frame();
    do_reset();
    for (int s = 0; s < 128; s++) begin
      in_en = 1'b1;
      in_sync = (s == 0);
      tick();
      if (s == 0) begin
        total++; if (a7 !== 7'd0) begin bad++; $display("FAIL f_s0_addr got=%0d want=0", a7); end
        total++; if (e7 !== 1'b0) begin bad++; $display("FAIL f_s0_en_ff1 got=%b want=0", e7); end
        total++; if (ef !== 1'b1) begin bad++; $display("FAIL f_s0_en_ff0 got=%b want=1", ef); end
        total++; if (bf !== 1'b1) begin bad++; $display("FAIL f_s0_byp_ff0 got=%b want=1", bf); end
        total++; if (y7 !== 1'b1) begin bad++; $display("FAIL f_s0_busy got=%b want=1", y7); end
      end
      if (s == 1) begin
        total++; if (e7 !== 1'b1) begin bad++; $display("FAIL f_s1_en_ff1 got=%b want=1", e7); end
        total++; if (b7 !== 1'b1) begin bad++; $display("FAIL f_s1_byp got=%b want=1", b7); end
      end
      if (s == 5) begin
        total++; if (a3 !== 7'd16) begin bad++; $display("FAIL n3_s5_addr got=%0d want=16", a3); end
      end
      if (s == 7) begin
        total++; if (a3 !== 7'd48) begin bad++; $display("FAIL n3_s7_addr got=%0d want=48", a3); end
      end
      if (s == 8) begin
        total++; if (l3 !== 1'b1) begin bad++; $display("FAIL n3_s7_last got=%b want=1", l3); end
        total++; if (a3 !== 7'd0) begin bad++; $display("FAIL n3_b2b_addr got=%0d want=0", a3); end
      end
      if (s == 9) begin
        total++; if (l3 !== 1'b0) begin bad++; $display("FAIL n3_s8_last got=%b want=0", l3); end
      end
      if (s == 11) begin
        total++; if (a5 !== 7'd24) begin bad++; $display("FAIL n5_s11_addr got=%0d want=24", a5); end
      end
      if (s == 30) begin
        total++; if (a5 !== 7'd72) begin bad++; $display("FAIL n5_s30_addr got=%0d want=72", a5); end
      end
      if (s == 31) begin
        total++; if (a5 !== 7'd84) begin bad++; $display("FAIL n5_s31_addr got=%0d want=84", a5); end
        total++; if (a7 !== 7'd0) begin bad++; $display("FAIL f_s31_addr got=%0d want=0", a7); end
      end
      if (s == 32) begin
        total++; if (l5 !== 1'b1) begin bad++; $display("FAIL n5_s31_last got=%b want=1", l5); end
        total++; if (b7 !== 1'b1) begin bad++; $display("FAIL f_s31_byp got=%b want=1", b7); end
      end
      if (s == 33) begin
        total++; if (a7 !== 7'd2) begin bad++; $display("FAIL f_s33_addr got=%0d want=2", a7); end
      end
      if (s == 34) begin
        total++; if (b7 !== 1'b0) begin bad++; $display("FAIL f_s33_byp got=%b want=0", b7); end
      end
      if (s == 69) begin
        total++; if (a7 !== 7'd5) begin bad++; $display("FAIL f_s69_addr got=%0d want=5", a7); end
      end
      if (s == 127) begin
        total++; if (a7 !== 7'd93) begin bad++; $display("FAIL f_s127_addr got=%0d want=93", a7); end
        total++; if (lf !== 1'b1) begin bad++; $display("FAIL f_s127_last_ff0 got=%b want=1", lf); end
        total++; if (l7 !== 1'b0) begin bad++; $display("FAIL f_s127_last_early got=%b want=0", l7); end
        total++; if (y7 !== 1'b0) begin bad++; $display("FAIL f_wrap_busy got=%b want=0", y7); end
      end
    end
    in_en = 1'b0;
    in_sync = 1'b0;
    tick();
    total++; if (l7 !== 1'b1) begin bad++; $display("FAIL f_s127_last got=%b want=1", l7); end
    total++; if (e7 !== 1'b1) begin bad++; $display("FAIL f_s127_en got=%b want=1", e7); end
    total++; if (ef !== 1'b0) begin bad++; $display("FAIL f_idle_en_ff0 got=%b want=0", ef); end
    total++; if (a7 !== 7'd93) begin bad++; $display("FAIL f_idle_hold got=%0d want=93", a7); end
  endtask

  // Bubble pattern on dut3: five samples (0..4) then 1,0,1,1,0,1 -> indices 5,-,6,7,-,0.
  task automatic test_bubbles();
    logic [5:0] pat;
    logic [6:0] exp_addr [6];
    pat = 6'b101101;  // bit 5 is cycle 0
    exp_addr[0] = 7'd16; exp_addr[1] = 7'd16; exp_addr[2] = 7'd0;
    exp_addr[3] = 7'd48; exp_addr[4] = 7'd48; exp_addr[5] = 7'd0;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      in_en = 1'b1;
      in_sync = (s == 0);
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      in_en = pat[5-c];
      in_sync = 1'b0;
      tick();
      total++; if (a3 !== exp_addr[c]) begin bad++;
        $display("FAIL bub_addr_c%0d got=%0d want=%0d", c, a3, exp_addr[c]); end
      total++; if (ef !== pat[5-c]) begin bad++;
        $display("FAIL bub_en_ff0_c%0d got=%b want=%b", c, ef, pat[5-c]); end
      total++; if (e3 !== ((c == 0) ? 1'b1 : pat[6-c])) begin bad++;
        $display("FAIL bub_en_ff1_c%0d got=%b", c, e3); end
      if (c == 4) begin
        total++; if (l3 !== 1'b1) begin bad++; $display("FAIL bub_last got=%b want=1", l3); end
      end
    end
    in_en = 1'b0;
    tick();
    total++; if (e3 !== 1'b1) begin bad++; $display("FAIL bub_en_ff1_tail got=%b want=1", e3); end
  endtask

  task automatic test_sync_mid();
    int n;
    do_reset();
    for (int s = 0; s < 50; s++) begin
      in_en = 1'b1;
      in_sync = (s == 0);
      tick();
    end
    total++; if (a7 !== 7'd34) begin bad++; $display("FAIL sm_s49_addr got=%0d want=34", a7); end
    in_sync = 1'b1;
    tick();
    total++; if (a7 !== 7'd0) begin bad++; $display("FAIL sm_sync_addr got=%0d want=0", a7); end
    total++; if (y7 !== 1'b1) begin bad++; $display("FAIL sm_busy got=%b want=1", y7); end
    total++; if (e7 !== 1'b1) begin bad++; $display("FAIL sm_drain_en got=%b want=1", e7); end
    total++; if (b7 !== 1'b0) begin bad++; $display("FAIL sm_drain_byp got=%b want=0", b7); end
    in_sync = 1'b0;
    n = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c == 1) begin
        total++; if (b7 !== 1'b1) begin bad++; $display("FAIL sm_sync_byp got=%b want=1", b7); end
      end
      if (lf === 1'b1) begin
        n = c;
        break;
      end
    end
    total++; if (n != 127) begin bad++; $display("FAIL sm_last_dist got=%0d want=127", n); end
    total++; if (yf !== 1'b0) begin bad++; $display("FAIL sm_end_busy got=%b want=0", yf); end
    in_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int s = 0; s < 80; s++) begin
      in_en = 1'b1;
      in_sync = (s == 0);
      tick();
    end
    total++; if (a7 !== 7'd15) begin bad++; $display("FAIL rm_pre_addr got=%0d want=15", a7); end
    reset_n = 1'b0;
    #1;
    total++; if ({a7, e7, b7, l7, y7} !== 11'd0) begin bad++;
      $display("FAIL rm_async_dut7 got=%b want=0", {a7, e7, b7, l7, y7}); end
    total++; if ({af, ef, bf, lf, yf} !== 11'd0) begin bad++;
      $display("FAIL rm_async_dut7f0 got=%b want=0", {af, ef, bf, lf, yf}); end
    in_en = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int s = 0; s < 34; s++) begin
      in_en = 1'b1;
      in_sync = 1'b0;
      tick();
      if (s == 0) begin
        total++; if (y7 !== 1'b1) begin bad++; $display("FAIL rm_post_busy got=%b want=1", y7); end
      end
      if (s == 33) begin
        total++; if (a7 !== 7'd2) begin bad++; $display("FAIL rm_post_s33 got=%0d want=2", a7); end
      end
    end
    in_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bubbles();
    test_sync_mid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
